// File: rtl/mc_control_fsm_if.sv
// Control bus between the multi-cycle MIPS main control FSM and its datapath.
// The master side is the FSM: it reads the IR fields and ALU flag and drives the datapath controls.
interface mc_control_fsm_if #(
  parameter int unsigned STATE_W = 4
);
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               alu_zero;
  logic               mem_ready;
  logic               pc_en;
  logic               iord;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               reg_write;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [3:0]         alu_op;
  logic [1:0]         pc_source;
  logic               illegal_op;
  logic [STATE_W-1:0] state;

  modport master (
    input  opcode, funct, alu_zero, mem_ready,
    output pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op, state
  );

  modport slave (
    output opcode, funct, alu_zero, mem_ready,
    input  pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op, state
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main control unit: Moore FSM for fetch/decode/execute/memory/writeback.
// Optional feature macro MEM_WAIT_EN: FETCH/MEMRD/MEMWR stall until mem_ready=1.
module mc_control_fsm #(
  parameter int unsigned STATE_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  mc_control_fsm_if.master  bus
);

  localparam logic [STATE_W-1:0] S_FETCH   = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE  = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEMADDR = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEMRD   = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEMWB   = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEMWR   = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_EXEC_R  = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_ALUWB   = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_BRANCH  = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_JUMP    = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_EXEC_I  = STATE_W'(10);

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [3:0]         r_alu_op;
  logic               r_funct_ok;
  logic [3:0]         i_alu_op;
  logic               op_legal;
  logic               mem_done;

`ifdef MEM_WAIT_EN
  assign mem_done = bus.mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign mem_done         = 1'b1;
`endif

  // Instruction field decode shared by next-state and output logic
  always_comb begin
    r_alu_op   = ALU_NOP;
    r_funct_ok = 1'b1;
    case (bus.funct)
      6'h20, 6'h21: r_alu_op = ALU_ADD;
      6'h22, 6'h23: r_alu_op = ALU_SUB;
      6'h24:        r_alu_op = ALU_AND;
      6'h25:        r_alu_op = ALU_OR;
      6'h26:        r_alu_op = ALU_XOR;
      6'h27:        r_alu_op = ALU_NOR;
      6'h2A:        r_alu_op = ALU_SLT;
      default:      r_funct_ok = 1'b0;
    endcase

    i_alu_op = (bus.opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;

    case (bus.opcode)
      OP_RTYPE:                              op_legal = r_funct_ok;
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J,
      OP_ADDI, OP_ADDIU, OP_SLTI:            op_legal = 1'b1;
      default:                               op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next state; unused encodings fall back to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = mem_done ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (!op_legal) state_d = S_FETCH;
        else begin
          case (bus.opcode)
            OP_RTYPE:                    state_d = S_EXEC_R;
            OP_LW, OP_SW:                state_d = S_MEMADDR;
            OP_BEQ, OP_BNE:              state_d = S_BRANCH;
            OP_J:                        state_d = S_JUMP;
            default:                     state_d = S_EXEC_I;
          endcase
        end
      end
      S_MEMADDR: state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = mem_done ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = mem_done ? S_FETCH : S_MEMWR;
      S_EXEC_R:  state_d = S_ALUWB;
      S_EXEC_I:  state_d = S_ALUWB;
      default:   state_d = S_FETCH;
    endcase
  end

  assign bus.state = state_q;

  // Moore outputs; held at idle values while reset is asserted
  always_comb begin
    bus.pc_en      = 1'b0;
    bus.iord       = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = ALU_NOP;
    bus.pc_source  = 2'b00;
    bus.illegal_op = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          bus.mem_read  = 1'b1;
          bus.ir_write  = mem_done;
          bus.pc_en     = mem_done;
          bus.alu_src_b = 2'b01;
          bus.alu_op    = ALU_ADD;
        end
        S_DECODE: begin
          bus.alu_src_b  = 2'b11;
          bus.alu_op     = ALU_ADD;
          bus.illegal_op = ~op_legal;
        end
        S_MEMADDR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
          bus.alu_op    = ALU_ADD;
        end
        S_MEMRD: begin
          bus.mem_read = 1'b1;
          bus.iord     = 1'b1;
        end
        S_MEMWB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          bus.mem_write = 1'b1;
          bus.iord      = 1'b1;
        end
        S_EXEC_R: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = r_alu_op;
        end
        S_EXEC_I: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
          bus.alu_op    = i_alu_op;
        end
        S_ALUWB: begin
          bus.reg_write = 1'b1;
          bus.reg_dst   = (bus.opcode == OP_RTYPE);
        end
        S_BRANCH: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = ALU_SUB;
          bus.pc_source = 2'b01;
          bus.pc_en     = (bus.opcode == OP_BNE) ? ~bus.alu_zero : bus.alu_zero;
        end
        S_JUMP: begin
          bus.pc_source = 2'b10;
          bus.pc_en     = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: stimulus queues hand-computed per-cycle outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_mc_control_fsm;

  logic clk;
  logic rst;

  mc_control_fsm_if #(.STATE_W(4)) bus ();

  mc_control_fsm #(.STATE_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // en = {pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a}
  typedef struct packed {
    logic [3:0] state;
    logic [8:0] en;
    logic [1:0] src_b;
    logic [3:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic exp_t mk(input logic [3:0] st, input logic [8:0] en, input logic [1:0] sb,
                              input logic [3:0] op, input logic [1:0] ps, input logic ill);
    exp_t e;
    e.state = st; e.en = en; e.src_b = sb; e.alu_op = op; e.pc_source = ps; e.illegal_op = ill;
    return e;
  endfunction

  function automatic exp_t e_fetch();
    return mk(4'd0, 9'b1_0_1_0_1_0_0_0_0, 2'b01, 4'b0010, 2'b00, 1'b0);
  endfunction

  function automatic exp_t e_decode(input logic ill);
    return mk(4'd1, 9'b0, 2'b11, 4'b0010, 2'b00, ill);
  endfunction

  function automatic exp_t e_idle(input logic [3:0] st);
    return mk(st, 9'b0, 2'b00, 4'b1111, 2'b00, 1'b0);
  endfunction

  // Queue the expected outputs for the current cycle, then advance to just after the next edge
  task automatic expect_cycle(input string nm, input exp_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic do_r(input logic [5:0] f, input logic [3:0] op);
    bus.opcode = 6'h00; bus.funct = f;
    expect_cycle("r_fetch",  e_fetch());
    expect_cycle("r_decode", e_decode(1'b0));
    expect_cycle("r_exec",   mk(4'd6, 9'b0_0_0_0_0_0_0_0_1, 2'b00, op, 2'b00, 1'b0));
    expect_cycle("r_aluwb",  mk(4'd7, 9'b0_0_0_0_0_1_1_0_0, 2'b00, 4'b1111, 2'b00, 1'b0));
  endtask

  task automatic do_i(input logic [5:0] opc, input logic [3:0] op);
    bus.opcode = opc; bus.funct = 6'h3F;
    expect_cycle("i_fetch",  e_fetch());
    expect_cycle("i_decode", e_decode(1'b0));
    expect_cycle("i_exec",   mk(4'd10, 9'b0_0_0_0_0_0_0_0_1, 2'b10, op, 2'b00, 1'b0));
    expect_cycle("i_aluwb",  mk(4'd7, 9'b0_0_0_0_0_1_0_0_0, 2'b00, 4'b1111, 2'b00, 1'b0));
  endtask

  task automatic do_lw();
    bus.opcode = 6'h23; bus.funct = 6'h00;
    expect_cycle("lw_fetch",   e_fetch());
    expect_cycle("lw_decode",  e_decode(1'b0));
    expect_cycle("lw_memaddr", mk(4'd2, 9'b0_0_0_0_0_0_0_0_1, 2'b10, 4'b0010, 2'b00, 1'b0));
    expect_cycle("lw_memrd",   mk(4'd3, 9'b0_1_1_0_0_0_0_0_0, 2'b00, 4'b1111, 2'b00, 1'b0));
    expect_cycle("lw_memwb",   mk(4'd4, 9'b0_0_0_0_0_1_0_1_0, 2'b00, 4'b1111, 2'b00, 1'b0));
  endtask

  task automatic do_sw();
    bus.opcode = 6'h2B; bus.funct = 6'h20;
    expect_cycle("sw_fetch",   e_fetch());
    expect_cycle("sw_decode",  e_decode(1'b0));
    expect_cycle("sw_memaddr", mk(4'd2, 9'b0_0_0_0_0_0_0_0_1, 2'b10, 4'b0010, 2'b00, 1'b0));
    expect_cycle("sw_memwr",   mk(4'd5, 9'b0_1_0_1_0_0_0_0_0, 2'b00, 4'b1111, 2'b00, 1'b0));
  endtask

  task automatic do_branch(input logic [5:0] opc, input logic zero, input logic pe);
    bus.opcode = opc; bus.funct = 6'h00; bus.alu_zero = zero;
    expect_cycle("br_fetch",  e_fetch());
    expect_cycle("br_decode", e_decode(1'b0));
    expect_cycle("br_branch", mk(4'd8, {pe, 8'b0000_0001}, 2'b00, 4'b0110, 2'b01, 1'b0));
  endtask

  task automatic do_jump();
    bus.opcode = 6'h02; bus.funct = 6'h00;
    expect_cycle("j_fetch",  e_fetch());
    expect_cycle("j_decode", e_decode(1'b0));
    expect_cycle("j_jump",   mk(4'd9, 9'b1_0_0_0_0_0_0_0_0, 2'b00, 4'b1111, 2'b10, 1'b0));
  endtask

  task automatic do_illegal(input logic [5:0] opc, input logic [5:0] f);
    bus.opcode = opc; bus.funct = f;
    expect_cycle("ill_fetch",  e_fetch());
    expect_cycle("ill_decode", e_decode(1'b1));
  endtask

  // Monitor: every cycle the DUT presents outputs; compare if an expectation is pending
  initial begin
    exp_t e, act;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        act = {bus.state,
               bus.pc_en, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write,
               bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
               bus.alu_src_b, bus.alu_op, bus.pc_source, bus.illegal_op};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s @%0t: got state=%0d en=%b sb=%b op=%b ps=%b ill=%b, expected state=%0d en=%b sb=%b op=%b ps=%b ill=%b",
                   nm, $time, act.state, act.en, act.src_b, act.alu_op, act.pc_source, act.illegal_op,
                   e.state, e.en, e.src_b, e.alu_op, e.pc_source, e.illegal_op);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.opcode = 6'h00; bus.funct = 6'h00; bus.alu_zero = 1'b0; bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    expect_cycle("reset0", e_idle(4'd0));
    expect_cycle("reset1", e_idle(4'd0));
    rst = 1'b0;

    do_r(6'h20, 4'b0010);
    do_r(6'h22, 4'b0110);
    do_r(6'h24, 4'b0000);
    do_r(6'h25, 4'b0001);
    do_r(6'h26, 4'b0011);
    do_r(6'h27, 4'b1100);
    do_r(6'h2A, 4'b0111);
    do_lw();
    do_sw();
    do_branch(6'h04, 1'b1, 1'b1);
    do_branch(6'h04, 1'b0, 1'b0);
    do_branch(6'h05, 1'b1, 1'b0);
    do_branch(6'h05, 1'b0, 1'b1);
    do_jump();
    do_i(6'h08, 4'b0010);
    do_i(6'h09, 4'b0010);
    do_i(6'h0A, 4'b0111);
    do_illegal(6'h3F, 6'h20);
    do_illegal(6'h00, 6'h3F);

    // Reset while in MEMRD: outputs idle during reset, FETCH right after
    bus.opcode = 6'h23;
    expect_cycle("rst_fetch",   e_fetch());
    expect_cycle("rst_decode",  e_decode(1'b0));
    expect_cycle("rst_memaddr", mk(4'd2, 9'b0_0_0_0_0_0_0_0_1, 2'b10, 4'b0010, 2'b00, 1'b0));
    rst = 1'b1;
    expect_cycle("rst_in_memrd", e_idle(4'd3));
    rst = 1'b0;
    do_jump();

`ifdef MEM_WAIT_EN
    bus.mem_ready = 1'b0;
    bus.opcode = 6'h02;
    for (int i = 0; i < 3; i++)
      expect_cycle("fetch_wait", mk(4'd0, 9'b0_0_1_0_0_0_0_0_0, 2'b01, 4'b0010, 2'b00, 1'b0));
    bus.mem_ready = 1'b1;
    expect_cycle("fetch_ready", e_fetch());
    expect_cycle("wait_decode", e_decode(1'b0));
    expect_cycle("wait_jump",   mk(4'd9, 9'b1_0_0_0_0_0_0_0_0, 2'b00, 4'b1111, 2'b10, 1'b0));
`else
    bus.mem_ready = 1'b0;
    do_jump();
    do_lw();
    bus.mem_ready = 1'b1;
`endif
    do_r(6'h21, 4'b0010);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
